// File: rtl/ccd_line2axis_v2.sv
// Linear-CCD line framer: strips dummy pixels, windows/pads each line and streams it out over AXI4-Stream.
// Define CCD2AXIS_SAT_EN to saturate pixels whose bits above the output window are non-zero.
//   state   | meaning
//   IDLE    | waiting for the first sample of a line
//   PRE     | discarding leading dummy samples
//   ACTIVE  | pushing effective samples
//   POST    | discarding trailing dummy samples
//   WAITLOW | ignoring samples until the strobe drops
//   PAD     | pushing zero pixels to complete a short line
module ccd_line2axis_v2 #(
  parameter int DATA_WIDTH      = 12,
  parameter int OUT_WIDTH       = 8,
  parameter int EFFECT_COLS     = 2048,
  parameter int PRE_DUMMY_COLS  = 32,
  parameter int POST_DUMMY_COLS = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  tvalid,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [10:0]           rows,
  input  logic [3:0]            shift,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  err_clr,
  output logic                  ovf,
  output logic                  short_line
);
  localparam int COL_W     = $clog2(EFFECT_COLS + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int SHIFT_MAX = DATA_WIDTH - OUT_WIDTH;
  localparam logic [COL_W-1:0] EFF_LAST  = COL_W'(EFFECT_COLS - 1);
  localparam logic [COL_W-1:0] PRE_LAST  = COL_W'(PRE_DUMMY_COLS - 1);
  localparam logic [COL_W-1:0] POST_LAST = COL_W'(POST_DUMMY_COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACTIVE, S_POST, S_WAITLOW, S_PAD} state_t;

  state_t                  state, state_nx, st_eff;
  logic [COL_W-1:0]        col_cnt, col_nx, cnt_eff;
  logic [10:0]             row_cnt, row_nx, rows_lat, rows_nx, rows_m1;
  logic                    vld_q, fall_q;
  logic [DATA_WIDTH-1:0]   dat_q, shifted;
  logic [OUT_WIDTH-1:0]    pix_win, push_pix;
  logic                    push, push_last, push_user, short_set, line_done;
  int                      s_cl;

  logic [OUT_WIDTH+1:0]    mem [FIFO_DEPTH];
  logic [OUT_WIDTH+1:0]    rd_word;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    full, pop, wr_en, drop;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      vld_q  <= tvalid;
      dat_q  <= tdata;
      fall_q <= vld_q & ~tvalid;
    end
  end

  always_comb begin
    s_cl    = (int'(shift) > SHIFT_MAX) ? SHIFT_MAX : int'(shift);
    shifted = dat_q >> s_cl;
    pix_win = shifted[OUT_WIDTH-1:0];
`ifdef CCD2AXIS_SAT_EN
    if ((shifted >> OUT_WIDTH) != '0) pix_win = '1;
`endif
  end

  // The first sample of a line is handled in IDLE as if the FSM were already in PRE (or ACTIVE).
  always_comb begin
    st_eff  = state;
    cnt_eff = col_cnt;
    if (state == S_IDLE) begin
      st_eff  = (PRE_DUMMY_COLS > 0) ? S_PRE : S_ACTIVE;
      cnt_eff = (PRE_DUMMY_COLS > 0) ? PRE_LAST : EFF_LAST;
    end
  end

  always_comb begin
    state_nx  = state;
    col_nx    = col_cnt;
    row_nx    = row_cnt;
    rows_nx   = rows_lat;
    rows_m1   = '0;
    push      = 1'b0;
    push_pix  = '0;
    push_last = 1'b0;
    push_user = 1'b0;
    short_set = 1'b0;
    line_done = 1'b0;
    case (state)
      S_IDLE, S_PRE, S_ACTIVE, S_POST: begin
        if (vld_q) begin
          if (state == S_IDLE && row_cnt == '0) rows_nx = rows;
          case (st_eff)
            S_PRE: begin
              if (cnt_eff == '0) begin
                state_nx = S_ACTIVE;
                col_nx   = EFF_LAST;
              end else begin
                state_nx = S_PRE;
                col_nx   = cnt_eff - COL_W'(1);
              end
            end
            S_ACTIVE: begin
              push      = 1'b1;
              push_pix  = pix_win;
              push_last = (cnt_eff == '0);
              push_user = (cnt_eff == EFF_LAST) && (row_cnt == '0);
              if (cnt_eff == '0) begin
                line_done = 1'b1;
                state_nx  = (POST_DUMMY_COLS > 0) ? S_POST : S_WAITLOW;
                col_nx    = (POST_DUMMY_COLS > 0) ? POST_LAST : '0;
              end else begin
                state_nx = S_ACTIVE;
                col_nx   = cnt_eff - COL_W'(1);
              end
            end
            S_POST: begin
              if (cnt_eff == '0) begin
                state_nx = S_WAITLOW;
                col_nx   = '0;
              end else begin
                col_nx = cnt_eff - COL_W'(1);
              end
            end
            default: ;
          endcase
        end else if (fall_q) begin
          if (state == S_ACTIVE) begin
            state_nx  = S_PAD;
            short_set = 1'b1;
          end else begin
            state_nx = S_IDLE;
            col_nx   = '0;
          end
        end
      end
      S_WAITLOW: begin
        if (!vld_q) begin
          state_nx = S_IDLE;
          col_nx   = '0;
        end
      end
      S_PAD: begin
        push      = 1'b1;
        push_last = (col_cnt == '0);
        push_user = (col_cnt == EFF_LAST) && (row_cnt == '0);
        if (col_cnt == '0) begin
          line_done = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          col_nx = col_cnt - COL_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    rows_m1 = (rows_nx == '0) ? '0 : rows_nx - 11'd1;
    if (line_done) row_nx = (row_cnt >= rows_m1) ? '0 : row_cnt + 11'd1;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      col_cnt  <= '0;
      row_cnt  <= '0;
      rows_lat <= '0;
    end else begin
      state    <= state_nx;
      col_cnt  <= col_nx;
      row_cnt  <= row_nx;
      rows_lat <= rows_nx;
    end
  end

  // Show-ahead FIFO; a full FIFO still accepts a push when the head is popped in the same cycle.
  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign wr_en         = push & (~full | pop);
  assign drop          = push & full & ~pop;
  assign rd_word       = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = rd_word;

  always_ff @(posedge pixel_clk) begin
    if (wr_en) mem[wr_ptr] <= {push_user, push_last, push_pix};
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf        <= 1'b0;
      short_line <= 1'b0;
    end else if (err_clr) begin
      ovf        <= 1'b0;
      short_line <= 1'b0;
    end else begin
      if (drop)      ovf        <= 1'b1;
      if (short_set) short_line <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ccd_line2axis_v2.sv
// Bench for ccd_line2axis_v2: line-level model of the expected AXI beats plus directed frame scenarios.
module tb_ccd_line2axis_v2;
  localparam int DW    = 12;
  localparam int OW    = 8;
  localparam int EFF   = 2048;
  localparam int PRE   = 32;
  localparam int POST  = 8;
  localparam int DEPTH = 16;
  localparam int FULL  = PRE + EFF + POST;

  logic          pixel_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tvalid = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [10:0]   rows = 11'd3;
  logic [3:0]    shift = 4'd0;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          err_clr = 1'b0;
  logic          ovf;
  logic          short_line;

  ccd_line2axis_v2 #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .EFFECT_COLS(EFF),
    .PRE_DUMMY_COLS(PRE), .POST_DUMMY_COLS(POST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .tvalid(tvalid), .tdata(tdata),
    .rows(rows), .shift(shift), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .err_clr(err_clr), .ovf(ovf), .short_line(short_line)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  logic [OW+1:0] exp_q[$];
  logic [OW+1:0] pop_log[$];
  int mrow  = 0;
  int mrows = 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Every negedge: hold-stability while stalled, and each handshake beat against the model queue.
  initial begin
    logic stall_prev;
    logic [OW+1:0] stall_word, word, exp;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge pixel_clk);
      word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!m_axis_tvalid || word != stall_word) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b word=%h required valid=1 word=%h",
                     m_axis_tvalid, word, stall_word);
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_word = word;
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat %0d: got word=%h required no beat", pop_log.size(), word);
          end else begin
            exp = exp_q.pop_front();
            if (word != exp) begin
              errors++;
              $display("FAIL beat %0d: got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                       pop_log.size(), word[OW+1], word[OW], word[OW-1:0], exp[OW+1], exp[OW], exp[OW-1:0]);
            end
          end
          pop_log.push_back(word);
        end
      end
    end
  end

  function automatic logic [DW-1:0] samp(input int i, input bit fixed, input logic [DW-1:0] val, input int seed);
    return fixed ? val : DW'(seed + i);
  endfunction

  function automatic logic [OW-1:0] model_pix(input logic [DW-1:0] d, input logic [3:0] sh);
    int s, v, w;
    s = (int'(sh) > DW - OW) ? DW - OW : int'(sh);
    v = int'(d);
    w = (v / (1 << s)) % (1 << OW);
`ifdef CCD2AXIS_SAT_EN
    if (v / (1 << (s + OW)) != 0) w = (1 << OW) - 1;
`endif
    return w[OW-1:0];
  endfunction

  // Expected beats of one line of n samples; only the first 'keep' beats survive (overflow case).
  task automatic model_line(input int n, input bit fixed, input logic [DW-1:0] val, input int seed, input int keep);
    int k, pushed;
    logic [OW-1:0] px;
    pushed = 0;
    if (mrow == 0) mrows = (rows == 11'd0) ? 1 : int'(rows);
    if (n < PRE) return;
    k = (n - PRE > EFF) ? EFF : n - PRE;
    for (int j = 0; j < EFF; j++) begin
      px = (j < k) ? model_pix(samp(PRE + j, fixed, val, seed), shift) : '0;
      if (pushed < keep) begin
        exp_q.push_back({(j == 0 && mrow == 0), (j == EFF - 1), px});
        pushed++;
      end
    end
    mrow = (mrow + 1 >= mrows) ? 0 : mrow + 1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    @(posedge pixel_clk);
    #1;
    tvalid = v;
    tdata  = d;
  endtask

  task automatic send_line(input int n, input bit fixed, input logic [DW-1:0] val, input int seed);
    model_line(n, fixed, val, seed, EFF);
    for (int i = 0; i < n; i++) drive(1'b1, samp(i, fixed, val, seed));
    drive(1'b0, '0);
    repeat ((n < PRE + EFF) ? EFF + 8 : 4) @(posedge pixel_clk);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 20000) begin
      @(posedge pixel_clk);
      t++;
    end
    repeat (4) @(posedge pixel_clk);
    chk({tag, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic stats(input int base, output int n, output int nu, output int nl);
    logic [OW+1:0] w;
    n = pop_log.size() - base;
    nu = 0;
    nl = 0;
    for (int i = base; i < pop_log.size(); i++) begin
      w = pop_log[i];
      if (w[OW+1]) nu++;
      if (w[OW]) nl++;
    end
  endtask

  function automatic logic [OW+1:0] beat_at(input int idx);
    return (idx < pop_log.size()) ? pop_log[idx] : '0;
  endfunction

  task automatic clear_flags(input string tag);
    @(posedge pixel_clk); #1; err_clr = 1'b1;
    @(posedge pixel_clk); #1; err_clr = 1'b0;
    @(negedge pixel_clk);
    chk({tag, "_ovf_clr"}, ovf, 0);
    chk({tag, "_short_clr"}, short_line, 0);
  endtask

  task automatic window_line(input logic [3:0] sh, input logic [DW-1:0] val, input logic [OW-1:0] req,
                             input bit lat_chk, input string tag);
    int base;
    logic [OW+1:0] w;
    base  = pop_log.size();
    shift = sh;
    model_line(PRE + 1, 1'b1, val, 0, EFF);
    for (int i = 0; i < PRE + 1; i++) drive(1'b1, val);
    drive(1'b0, '0);
    if (lat_chk) begin
      @(negedge pixel_clk);
      chk("latency_n_plus_1", m_axis_tvalid, 0);
      @(negedge pixel_clk);
      chk("latency_n_plus_2", m_axis_tvalid, 1);
    end
    repeat (EFF + 8) @(posedge pixel_clk);
    wait_drain(tag);
    w = beat_at(base);
    chk({tag, "_pix"}, w[OW-1:0], req);
    chk({tag, "_short"}, short_line, 1);
  endtask

  initial begin
    int base, n, nu, nl, nz;
    logic [OW+1:0] w;

    repeat (3) begin
      @(negedge pixel_clk);
      chk("reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, short_line}, 0);
    end
    @(posedge pixel_clk); #1; rst_n = 1'b1; m_axis_tready = 1'b1;
    @(negedge pixel_clk);
    chk("after_reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, short_line}, 0);

    // nominal 3-row frame, shift beyond range clamps to 4
    shift = 4'd7;
    rows  = 11'd3;
    base  = pop_log.size();
    for (int r = 0; r < 3; r++) send_line(FULL, 1'b0, '0, r * 5);
    wait_drain("nominal");
    stats(base, n, nu, nl);
    chk("nominal_beats", n, 6144);
    chk("nominal_tuser_count", nu, 1);
    chk("nominal_tlast_count", nl, 3);
    w = beat_at(base);        chk("nominal_tuser_beat0", w[OW+1], 1);
    w = beat_at(base + 2047); chk("nominal_tlast_2047", w[OW], 1);
    w = beat_at(base + 4095); chk("nominal_tlast_4095", w[OW], 1);
    w = beat_at(base + 6143); chk("nominal_tlast_6143", w[OW], 1);
    chk("nominal_ovf", ovf, 0);
    chk("nominal_short", short_line, 0);

    window_line(4'd4, 12'hABC, 8'hAB, 1'b1, "win_abc");
    window_line(4'd0, 12'h1FF, 8'hFF, 1'b0, "win_1ff");
`ifdef CCD2AXIS_SAT_EN
    window_line(4'd0, 12'h100, 8'hFF, 1'b0, "win_100");
`else
    window_line(4'd0, 12'h100, 8'h00, 1'b0, "win_100");
`endif
    clear_flags("win");

    // short line: PRE + 100 samples
    shift = 4'd0;
    base  = pop_log.size();
    send_line(PRE + 100, 1'b0, '0, 1);
    wait_drain("short");
    stats(base, n, nu, nl);
    chk("short_beats", n, 2048);
    chk("short_tlast_count", nl, 1);
    w = beat_at(base + 2047); chk("short_tlast_2047", w[OW], 1);
    nz = 0;
    for (int i = 100; i < 2048; i++) begin
      w = beat_at(base + i);
      if (w[OW-1:0] == '0) nz++;
    end
    chk("short_zero_pads", nz, 1948);
    chk("short_flag", short_line, 1);
    clear_flags("short");

    // back-pressure over a whole line, with err_clr colliding with a drop
    m_axis_tready = 1'b0;
    base = pop_log.size();
    model_line(FULL, 1'b0, '0, 9, DEPTH);
    for (int i = 0; i < FULL; i++) begin
      drive(1'b1, samp(i, 1'b0, '0, 9));
      err_clr = (i == PRE + 200);
      if (i == PRE + 201) begin
        @(negedge pixel_clk);
        chk("err_clr_priority", ovf, 0);
      end
      if (i == PRE + 202) begin
        @(negedge pixel_clk);
        chk("ovf_reset_after_clr", ovf, 1);
      end
    end
    drive(1'b0, '0);
    repeat (4) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("ovf_flag", ovf, 1);
    chk("ovf_tvalid_held", m_axis_tvalid, 1);
    @(posedge pixel_clk); #1; m_axis_tready = 1'b1;
    wait_drain("ovf");
    stats(base, n, nu, nl);
    chk("ovf_buffered_beats", n, DEPTH);
    base = pop_log.size();
    send_line(FULL, 1'b0, '0, 3);
    wait_drain("ovf_next");
    stats(base, n, nu, nl);
    chk("ovf_next_beats", n, 2048);
    chk("ovf_next_tlast_count", nl, 1);
    w = beat_at(base + 2047); chk("ovf_next_tlast_2047", w[OW], 1);
    chk("ovf_sticky", ovf, 1);
    clear_flags("ovf");

    // reset during row 1 of a frame
    send_line(FULL, 1'b0, '0, 11);
    wait_drain("rst_row0");
    for (int j = 0; j < 50; j++) exp_q.push_back({1'b0, 1'b0, model_pix(samp(PRE + j, 1'b0, '0, 13), shift)});
    for (int i = 0; i < PRE + 50; i++) drive(1'b1, samp(i, 1'b0, '0, 13));
    @(posedge pixel_clk); #1; rst_n = 1'b0; tvalid = 1'b0;
    exp_q.delete();
    mrow = 0;
    repeat (3) begin
      @(negedge pixel_clk);
      chk("midframe_reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, short_line}, 0);
    end
    @(posedge pixel_clk); #1; rst_n = 1'b1;
    base = pop_log.size();
    send_line(FULL, 1'b0, '0, 17);
    wait_drain("rst_next");
    stats(base, n, nu, nl);
    chk("rst_next_beats", n, 2048);
    w = beat_at(base); chk("rst_next_tuser", w[OW+1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
